// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetcher: FSM states, in-flight tag and bus encodings.
package fetch_pkg;

  localparam int unsigned PC_STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } bus_trans_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } bus_resp_t;

  typedef struct packed {
    logic        epoch;
    logic [31:0] address;
  } inflight_tag_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO between the bus data phase and decode; flush empties it in one cycle.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic                           i_flush,
  input  logic [WIDTH-1:0]               i_data,
  output logic                           o_valid,
  output logic [WIDTH-1:0]               o_data,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != FULL_C);
  assign w_do_pop  = i_pop && (r_count != {CW{1'b0}});

  // Storage, pointers and fill count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + {{(CW-1){1'b0}}, w_do_push} - {{(CW-1){1'b0}}, w_do_pop};
    end
  end

  assign o_valid = (r_count != {CW{1'b0}});
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher: owns the PC, pipelines fetches over the bus and buffers them for decode.
// Build option FETCH_BURST_EN: back-to-back sequential fetches are marked SEQ instead of NONSEQ.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = PC_STEP_DEFAULT
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               i_redirect,
  input  logic [31:0]                        i_redirect_pc,
  output logic [31:0]                        o_bus_address,
  output logic                               o_bus_write,
  output logic [1:0]                         o_bus_trans,
  input  logic                               i_bus_ready,
  input  logic                               i_bus_response,
  input  logic [31:0]                        i_bus_read_data,
  input  logic                               i_bus_available,
  output logic                               o_to_decode_valid,
  output logic [31:0]                        o_to_decode_data,
  input  logic                               i_to_decode_ready,
  output logic                               o_fault,
  output logic [31:0]                        o_fault_pc,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_occupancy
);
  localparam int unsigned   CW      = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [31:0]   STEP_C  = 32'(PC_STEP);

  fetch_state_t  r_state;
  logic          r_epoch;
  logic [31:0]   r_pc;
  logic [1:0]    r_trans;
  logic          r_dp_valid;
  inflight_tag_t r_dp_tag;
  logic          r_fault;
  logic [31:0]   r_fault_pc;
  logic [CW-1:0] r_occupancy;

  logic          w_addr_done;
  logic          w_dp_done;
  logic          w_stale;
  logic          w_push;
  logic          w_fault_evt;
  logic          w_drop;
  logic          w_pop;
  logic          w_run_next;
  logic          w_issue;
  logic          w_dp_valid_next;
  logic          w_q_valid;
  logic [31:0]   w_q_data;
  logic [CW-1:0] w_q_count;
  logic [CW-1:0] w_occ_next;
  logic [1:0]    w_trans_next;

  // Bus phase completion, queue traffic and next-cycle issue decision.
  always_comb begin
    w_addr_done     = (r_trans != TRANS_IDLE) && i_bus_ready;
    w_dp_done       = r_dp_valid && i_bus_ready;
    w_stale         = i_redirect || (r_dp_tag.epoch != r_epoch) || (r_state != ST_RUN);
    w_push          = w_dp_done && !w_stale && (i_bus_response == RESP_OKAY)
                      && (w_q_count != DEPTH_C);
    w_fault_evt     = w_dp_done && !w_stale && (i_bus_response == RESP_ERROR);
    w_drop          = w_dp_done && !w_push;
    w_pop           = w_q_valid && i_to_decode_ready;
    w_dp_valid_next = i_bus_ready ? w_addr_done : r_dp_valid;
    // After a redirect only the transfer still on the bus keeps its slot reserved.
    if (i_redirect) begin
      w_occ_next = {{(CW-1){1'b0}}, w_dp_valid_next};
    end else begin
      w_occ_next = r_occupancy + {{(CW-1){1'b0}}, w_addr_done}
                   - {{(CW-1){1'b0}}, w_pop} - {{(CW-1){1'b0}}, w_drop};
    end
    w_run_next = i_redirect || ((r_state == ST_RUN) && !w_fault_evt)
                 || ((r_state == ST_IDLE) && i_bus_available);
    w_issue    = w_run_next && i_bus_available && (w_occ_next < DEPTH_C);
    if (!i_redirect && (r_trans != TRANS_IDLE) && !i_bus_ready) begin
      w_trans_next = r_trans;
    end else if (w_issue) begin
`ifdef FETCH_BURST_EN
      w_trans_next = (!i_redirect && (r_trans != TRANS_IDLE)) ? TRANS_SEQ : TRANS_NONSEQ;
`else
      w_trans_next = TRANS_NONSEQ;
`endif
    end else begin
      w_trans_next = TRANS_IDLE;
    end
  end

  // Fetch FSM with the PC, epoch, in-flight tag and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_epoch     <= 1'b0;
      r_pc        <= RESET_PC;
      r_trans     <= TRANS_IDLE;
      r_dp_valid  <= 1'b0;
      r_dp_tag    <= {1'b0, 32'h0000_0000};
      r_fault     <= 1'b0;
      r_fault_pc  <= 32'h0000_0000;
      r_occupancy <= {CW{1'b0}};
    end else begin
      r_trans     <= w_trans_next;
      r_dp_valid  <= w_dp_valid_next;
      r_occupancy <= w_occ_next;
      if (w_addr_done) begin
        r_dp_tag <= {r_epoch, r_pc};
      end
      if (i_redirect) begin
        r_state <= ST_RUN;
        r_epoch <= ~r_epoch;
        r_pc    <= i_redirect_pc;
        r_fault <= 1'b0;
      end else begin
        if (w_addr_done) begin
          r_pc <= r_pc + STEP_C;
        end
        case (r_state)
          ST_IDLE: begin
            if (i_bus_available) begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_fault_evt) begin
              r_state    <= ST_FAULT;
              r_fault    <= 1'b1;
              r_fault_pc <= r_dp_tag.address;
            end
          end
          ST_FAULT: r_state <= ST_FAULT;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (32)
  ) u_queue (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_data  (i_bus_read_data),
    .o_valid (w_q_valid),
    .o_data  (w_q_data),
    .o_count (w_q_count)
  );

  assign o_bus_address     = r_pc;
  assign o_bus_write       = 1'b0;
  assign o_bus_trans       = r_trans;
  assign o_to_decode_valid = w_q_valid;
  assign o_to_decode_data  = w_q_data;
  assign o_fault           = r_fault;
  assign o_fault_pc        = r_fault_pc;
  assign o_occupancy       = r_occupancy;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a pipelined bus memory model (word = address ^ C0DE_0000).
module tb_fetch_prefetch_unit;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RPC    = 32'h0000_0100;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
`ifdef FETCH_BURST_EN
  localparam logic [1:0] T_BURST  = 2'b11;
`else
  localparam logic [1:0] T_BURST  = 2'b10;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_bus_address;
  logic        o_bus_write;
  logic [1:0]  o_bus_trans;
  logic        i_bus_ready;
  logic        i_bus_response;
  logic [31:0] i_bus_read_data;
  logic        i_bus_available;
  logic        o_to_decode_valid;
  logic [31:0] o_to_decode_data;
  logic        i_to_decode_ready;
  logic        o_fault;
  logic [31:0] o_fault_pc;
  logic [2:0]  o_occupancy;

  int checks   = 0;
  int failures = 0;

  logic        mdp_valid;
  logic [31:0] mdp_addr;
  logic        err_en;
  logic [31:0] err_addr;
  logic [31:0] issued[$];
  logic [31:0] got[$];
  int          max_occ;

  always #5 clock = ~clock;

  fetch_prefetch_unit #(
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (RPC),
    .PC_STEP     (4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .i_redirect        (i_redirect),
    .i_redirect_pc     (i_redirect_pc),
    .o_bus_address     (o_bus_address),
    .o_bus_write       (o_bus_write),
    .o_bus_trans       (o_bus_trans),
    .i_bus_ready       (i_bus_ready),
    .i_bus_response    (i_bus_response),
    .i_bus_read_data   (i_bus_read_data),
    .i_bus_available   (i_bus_available),
    .o_to_decode_valid (o_to_decode_valid),
    .o_to_decode_data  (o_to_decode_data),
    .i_to_decode_ready (i_to_decode_ready),
    .o_fault           (o_fault),
    .o_fault_pc        (o_fault_pc),
    .o_occupancy       (o_occupancy)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] last_got();
    return (got.size() > 0) ? got[got.size()-1] : 32'hFFFF_FFFF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: log handshakes before the edge, then drive the memory data phase after it.
  task automatic cyc();
    logic        nv;
    logic [31:0] na;
    nv = mdp_valid;
    na = mdp_addr;
    if (i_bus_ready) begin
      nv = (o_bus_trans != T_IDLE);
      na = o_bus_address;
      if (o_bus_trans != T_IDLE) issued.push_back(o_bus_address);
    end
    if (o_to_decode_valid && i_to_decode_ready) got.push_back(o_to_decode_data);
    @(posedge clock);
    #1;
    mdp_valid       = nv;
    mdp_addr        = na;
    i_bus_read_data = nv ? mem_word(na) : 32'h0000_0000;
    i_bus_response  = nv && err_en && (na == err_addr);
    i_redirect      = 1'b0;
    if (int'(o_occupancy) > max_occ) max_occ = int'(o_occupancy);
  endtask

  task automatic do_reset(input logic dec_ready);
    reset             = 1'b0;
    i_redirect        = 1'b0;
    i_redirect_pc     = 32'h0000_0000;
    i_bus_ready       = 1'b1;
    i_bus_available   = 1'b1;
    i_bus_response    = 1'b0;
    i_bus_read_data   = 32'h0000_0000;
    i_to_decode_ready = dec_ready;
    mdp_valid         = 1'b0;
    mdp_addr          = 32'h0000_0000;
    err_en            = 1'b0;
    err_addr          = 32'h0000_0000;
    issued.delete();
    got.delete();
    max_occ = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset             = 1'b0;
    i_redirect        = 1'b0;
    i_redirect_pc     = 32'h0000_0000;
    i_bus_ready       = 1'b1;
    i_bus_available   = 1'b0;
    i_bus_response    = 1'b0;
    i_bus_read_data   = 32'h0000_0000;
    i_to_decode_ready = 1'b1;
    #12;
    check_eq("rst_addr",  o_bus_address, RPC);
    check_eq("rst_write", o_bus_write, 32'd0);
    check_eq("rst_trans", o_bus_trans, T_IDLE);
    check_eq("rst_valid", o_to_decode_valid, 32'd0);
    check_eq("rst_data",  o_to_decode_data, 32'd0);
    check_eq("rst_fault", o_fault, 32'd0);
    check_eq("rst_fpc",   o_fault_pc, 32'd0);
    check_eq("rst_occ",   o_occupancy, 32'd0);

    // Streaming fetch with always-ready memory and decode.
    do_reset(1'b1);
    cyc();
    check_eq("t1_trans0", o_bus_trans, T_NONSEQ);
    check_eq("t1_addr0",  o_bus_address, 32'h0000_0100);
    check_eq("t1_valid0", o_to_decode_valid, 32'd0);
    cyc();
    check_eq("t1_addr1",  o_bus_address, 32'h0000_0104);
    check_eq("t1_trans1", o_bus_trans, T_BURST);
    check_eq("t1_valid1", o_to_decode_valid, 32'd0);
    cyc();
    check_eq("t1_addr2",  o_bus_address, 32'h0000_0108);
    check_eq("t1_valid2", o_to_decode_valid, 32'd1);
    check_eq("t1_data2",  o_to_decode_data, mem_word(32'h0000_0100));
    check_eq("t1_occ2",   o_occupancy, 32'd2);
    cyc();
    check_eq("t1_data3",  o_to_decode_data, mem_word(32'h0000_0104));
    repeat (4) cyc();
    check_eq("t1_ndeliv", got.size(), 32'd5);
    check_eq("t1_last",   last_got(), mem_word(32'h0000_0110));

    // Decode stalled: queue fills to depth, then one issue per pop.
    do_reset(1'b0);
    repeat (12) cyc();
    check_eq("t2_nissue", issued.size(), 32'd4);
    check_eq("t2_trans",  o_bus_trans, T_IDLE);
    check_eq("t2_occ",    o_occupancy, 32'd4);
    check_eq("t2_head",   o_to_decode_data, mem_word(32'h0000_0100));
    i_to_decode_ready = 1'b1;
    cyc();
    i_to_decode_ready = 1'b0;
    check_eq("t2_reissue", o_bus_trans, T_NONSEQ);
    check_eq("t2_readdr",  o_bus_address, 32'h0000_0110);
    check_eq("t2_occ_pop", o_occupancy, 32'd3);
    repeat (6) cyc();
    check_eq("t2_nissue2", issued.size(), 32'd5);
    check_eq("t2_occ2",    o_occupancy, 32'd4);

    // Redirect while 0x108 is in its data phase and 0x10C in its address phase.
    do_reset(1'b1);
    repeat (4) cyc();
    check_eq("t3_pre_addr", o_bus_address, 32'h0000_010C);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0400;
    cyc();
    check_eq("t3_valid0", o_to_decode_valid, 32'd0);
    check_eq("t3_addr0",  o_bus_address, 32'h0000_0400);
    check_eq("t3_trans0", o_bus_trans, T_NONSEQ);
    check_eq("t3_occ0",   o_occupancy, 32'd1);
    cyc();
    check_eq("t3_valid1", o_to_decode_valid, 32'd0);
    check_eq("t3_occ1",   o_occupancy, 32'd1);
    cyc();
    check_eq("t3_valid2", o_to_decode_valid, 32'd1);
    check_eq("t3_data2",  o_to_decode_data, mem_word(32'h0000_0400));
    check_eq("t3_ndeliv", got.size(), 32'd2);
    repeat (3) cyc();
    check_eq("t3_maxocc", (max_occ <= 4), 32'd1);

    // ERROR response on 0x10C, then recovery by redirect to 0x200.
    do_reset(1'b1);
    err_en   = 1'b1;
    err_addr = 32'h0000_010C;
    repeat (6) cyc();
    check_eq("t4_fault",  o_fault, 32'd1);
    check_eq("t4_fpc",    o_fault_pc, 32'h0000_010C);
    check_eq("t4_trans",  o_bus_trans, T_IDLE);
    repeat (6) cyc();
    check_eq("t4_nissue", issued.size(), 32'd5);
    check_eq("t4_occ",    o_occupancy, 32'd0);
    check_eq("t4_ndeliv", got.size(), 32'd3);
    check_eq("t4_last",   last_got(), mem_word(32'h0000_0108));
    check_eq("t4_sticky", o_fault, 32'd1);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    cyc();
    check_eq("t4_clear",  o_fault, 32'd0);
    check_eq("t4_raddr",  o_bus_address, 32'h0000_0200);
    check_eq("t4_rtrans", o_bus_trans, T_NONSEQ);
    repeat (2) cyc();
    check_eq("t4_rvalid", o_to_decode_valid, 32'd1);
    check_eq("t4_rdata",  o_to_decode_data, mem_word(32'h0000_0200));

    // Memory wait states hold the address; an idle cycle restarts with NONSEQ.
    do_reset(1'b1);
    cyc();
    i_bus_ready = 1'b0;
    cyc();
    check_eq("t5_hold_a1", o_bus_address, 32'h0000_0100);
    check_eq("t5_hold_t1", o_bus_trans, T_NONSEQ);
    cyc();
    check_eq("t5_hold_a2", o_bus_address, 32'h0000_0100);
    check_eq("t5_hold_o2", o_occupancy, 32'd0);
    i_bus_ready = 1'b1;
    cyc();
    check_eq("t5_addr3",  o_bus_address, 32'h0000_0104);
    check_eq("t5_trans3", o_bus_trans, T_BURST);
    i_bus_available = 1'b0;
    cyc();
    check_eq("t5_idle",   o_bus_trans, T_IDLE);
    i_bus_available = 1'b1;
    cyc();
    check_eq("t5_restart_t", o_bus_trans, T_NONSEQ);
    check_eq("t5_restart_a", o_bus_address, 32'h0000_0108);
    cyc();
    check_eq("t5_next_t", o_bus_trans, T_BURST);
    check_eq("t5_next_a", o_bus_address, 32'h0000_010C);

    // Reset asserted mid-transfer; the late data phase must be ignored.
    do_reset(1'b1);
    repeat (4) cyc();
    i_bus_available = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("t6_trans", o_bus_trans, T_IDLE);
    check_eq("t6_addr",  o_bus_address, RPC);
    check_eq("t6_valid", o_to_decode_valid, 32'd0);
    check_eq("t6_data",  o_to_decode_data, 32'd0);
    check_eq("t6_occ",   o_occupancy, 32'd0);
    #1;
    reset = 1'b1;
    cyc();
    check_eq("t6_late_valid", o_to_decode_valid, 32'd0);
    check_eq("t6_late_occ",   o_occupancy, 32'd0);
    i_bus_available = 1'b1;
    cyc();
    check_eq("t6_re_trans", o_bus_trans, T_NONSEQ);
    check_eq("t6_re_addr",  o_bus_address, RPC);
    repeat (2) cyc();
    check_eq("t6_re_data",  o_to_decode_data, mem_word(RPC));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
